// File: rtl/rf_wb_pkg.sv
// ----------------------------------------------------------------------------
// rf_wb_pkg
// Shared definitions for the register-file writeback arbiter:
//   - default register index / data widths
//   - source index constants for the round-robin pointer
//   - the hardwired-zero register index
//   - slot_t: one holding-slot entry (valid, addr, data) at default widths
// ----------------------------------------------------------------------------
package rf_wb_pkg;

    localparam int RF_WB_ADDR_WIDTH = 5;
    localparam int RF_WB_DATA_WIDTH = 32;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic                        valid;
        logic [RF_WB_ADDR_WIDTH-1:0] addr;
        logic [RF_WB_DATA_WIDTH-1:0] data;
    } slot_t;

endpackage

// File: rtl/rf_wb_slot.sv
// ----------------------------------------------------------------------------
// rf_wb_slot
// Single-entry valid/ready holding register for one result producer.
// The slot accepts a new entry whenever it is empty or is being drained by
// the arbiter in the same cycle, so a streaming producer sees no bubble.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    producer handshake (in_ready is combinational)
//   in_addr/in_data      producer destination register and result
//   grant                arbiter drains the slot at the next edge
//   out_valid/addr/data  current slot contents
// ----------------------------------------------------------------------------
module rf_wb_slot
    import rf_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_WB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  grant,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  valid_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;

    // Room exists when empty or when the current entry leaves this cycle.
    assign in_ready  = rst_n & (~valid_r | grant);
    assign out_valid = valid_r;
    assign out_addr  = addr_r;
    assign out_data  = data_r;

    // Slot storage: load on handshake (takes priority over drain), clear on drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            data_r  <= {DATA_WIDTH{1'b0}};
        end else if (in_valid && in_ready) begin
            valid_r <= 1'b1;
            addr_r  <= in_addr;
            data_r  <= in_data;
        end else if (grant) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// rf_writeback_arbiter
// Write-side front end of the integer register file. Two result producers
// (src0 = ALU, src1 = LSU) each feed a one-entry holding slot; a round-robin
// arbiter drains one slot per cycle into the registered write port. A busy
// scoreboard tracks destinations allocated at issue and not yet written.
// Register 0 is never written and never busy.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   alloc_valid/alloc_addr     mark a destination as pending writeback
//   s0_* / s1_*                producer valid/ready/addr/data
//   waddr/wdata/wen            registered register-file write port
//   qaddr1/qbusy1, qaddr2/qbusy2  combinational scoreboard queries
// ----------------------------------------------------------------------------
module rf_writeback_arbiter
    import rf_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_WB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wen,
    input  logic [ADDR_WIDTH-1:0] qaddr1,
    output logic                  qbusy1,
    input  logic [ADDR_WIDTH-1:0] qaddr2,
    output logic                  qbusy2
);

    localparam int                    NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
    localparam logic [NUM_REGS-1:0]   ONE_HOT0  = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic                  slot0_valid_s, slot1_valid_s;
    logic [ADDR_WIDTH-1:0] slot0_addr_s,  slot1_addr_s;
    logic [DATA_WIDTH-1:0] slot0_data_s,  slot1_data_s;

    logic                  grant0_s, grant1_s, grant_any_s;
    logic [ADDR_WIDTH-1:0] grant_addr_s;
    logic [DATA_WIDTH-1:0] grant_data_s;
    logic                  grant_writes_s;

    logic                  ptr_r;
    logic [ADDR_WIDTH-1:0] waddr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  wen_r;

    logic [NUM_REGS-1:0]   busy_r;
    logic [NUM_REGS-1:0]   busy_set_s, busy_clr_s, busy_next_s;

    rf_wb_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s0_valid),
        .in_ready  (s0_ready),
        .in_addr   (s0_addr),
        .in_data   (s0_data),
        .grant     (grant0_s),
        .out_valid (slot0_valid_s),
        .out_addr  (slot0_addr_s),
        .out_data  (slot0_data_s)
    );

    rf_wb_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s1_ready),
        .in_addr   (s1_addr),
        .in_data   (s1_data),
        .grant     (grant1_s),
        .out_valid (slot1_valid_s),
        .out_addr  (slot1_addr_s),
        .out_data  (slot1_data_s)
    );

    // Round-robin grant among full slots; the pointer only breaks ties.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case ({slot1_valid_s, slot0_valid_s})
            2'b01: grant0_s = 1'b1;
            2'b10: grant1_s = 1'b1;
            2'b11: begin
                if (ptr_r == SRC0) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
    end

    // Mux the granted slot onto the write path.
    always_comb begin
        grant_any_s = grant0_s | grant1_s;
        if (grant1_s) begin
            grant_addr_s = slot1_addr_s;
            grant_data_s = slot1_data_s;
        end else begin
            grant_addr_s = slot0_addr_s;
            grant_data_s = slot0_data_s;
        end
    end

    // A drained entry for register 0 is consumed without a write.
    assign grant_writes_s = grant_any_s & (grant_addr_s != ZERO_ADDR);

    // Pointer moves to the source that did not win, for lone grants too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= SRC0;
        end else if (grant0_s) begin
            ptr_r <= SRC1;
        end else if (grant1_s) begin
            ptr_r <= SRC0;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Registered write port; address/data hold between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_r   <= 1'b0;
            waddr_r <= {ADDR_WIDTH{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
        end else if (grant_writes_s) begin
            wen_r   <= 1'b1;
            waddr_r <= grant_addr_s;
            wdata_r <= grant_data_s;
        end else begin
            wen_r   <= 1'b0;
        end
    end

    assign wen   = wen_r;
    assign waddr = waddr_r;
    assign wdata = wdata_r;

    // Clear is applied before set so a fresh allocation survives a
    // same-edge writeback of the previous producer. Bit 0 is forced low.
    assign busy_clr_s  = grant_writes_s ? (ONE_HOT0 << grant_addr_s) : {NUM_REGS{1'b0}};
    assign busy_set_s  = (alloc_valid && (alloc_addr != ZERO_ADDR))
                         ? (ONE_HOT0 << alloc_addr) : {NUM_REGS{1'b0}};
    assign busy_next_s = ((busy_r & ~busy_clr_s) | busy_set_s) & ~ONE_HOT0;

    // Pending-writeback scoreboard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Queries see pre-edge state, so an in-flight write still reads busy.
    assign qbusy1 = (qaddr1 != ZERO_ADDR) & busy_r[qaddr1];
    assign qbusy2 = (qaddr2 != ZERO_ADDR) & busy_r[qaddr2];

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_writeback_arbiter
// Directed scenarios followed by randomized traffic, all compared every
// cycle against a transaction-level model (per-source queues, a preferred
// source, a busy bit array and the expected write-port value).
// ----------------------------------------------------------------------------
module tb_rf_writeback_arbiter;
    import rf_wb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic        s0_valid, s0_ready;
    logic [4:0]  s0_addr;
    logic [31:0] s0_data;
    logic        s1_valid, s1_ready;
    logic [4:0]  s1_addr;
    logic [31:0] s1_data;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [4:0]  qaddr1, qaddr2;
    logic        qbusy1, qbusy2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    slot_t       m_q0[$];
    slot_t       m_q1[$];
    int          m_pref;
    bit [31:0]   m_busy;
    bit          m_wen;
    bit [4:0]    m_waddr;
    bit [31:0]   m_wdata;

    rf_writeback_arbiter #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .s0_valid    (s0_valid),
        .s0_ready    (s0_ready),
        .s0_addr     (s0_addr),
        .s0_data     (s0_data),
        .s1_valid    (s1_valid),
        .s1_ready    (s1_ready),
        .s1_addr     (s1_addr),
        .s1_data     (s1_data),
        .waddr       (waddr),
        .wdata       (wdata),
        .wen         (wen),
        .qaddr1      (qaddr1),
        .qbusy1      (qbusy1),
        .qaddr2      (qaddr2),
        .qbusy2      (qbusy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Which source writes back this cycle: -1 none, 0 src0, 1 src1.
    function automatic int m_winner();
        if (m_q0.size() != 0 && m_q1.size() != 0) return m_pref;
        else if (m_q0.size() != 0) return 0;
        else if (m_q1.size() != 0) return 1;
        else return -1;
    endfunction

    function automatic bit m_qbusy(input logic [4:0] a);
        return (a != 5'd0) && m_busy[a];
    endfunction

    // Compare every DUT output against the model, mid-cycle.
    task automatic sample();
        int w;
        @(negedge clk);
        w = m_winner();
        chk("s0_ready", 64'(s0_ready), 64'(rst_n && (m_q0.size() == 0 || w == 0)));
        chk("s1_ready", 64'(s1_ready), 64'(rst_n && (m_q1.size() == 0 || w == 1)));
        chk("wen",      64'(wen),      64'(m_wen));
        chk("waddr",    64'(waddr),    64'(m_waddr));
        chk("wdata",    64'(wdata),    64'(m_wdata));
        chk("qbusy1",   64'(qbusy1),   64'(m_qbusy(qaddr1)));
        chk("qbusy2",   64'(qbusy2),   64'(m_qbusy(qaddr2)));
    endtask

    // Apply the current inputs to the model, then cross the clock edge.
    task automatic advance();
        int    w;
        slot_t e;
        if (!rst_n) begin
            m_q0.delete();
            m_q1.delete();
            m_pref  = 0;
            m_busy  = 32'd0;
            m_wen   = 1'b0;
            m_waddr = 5'd0;
            m_wdata = 32'd0;
        end else begin
            w     = m_winner();
            m_wen = 1'b0;
            if (w >= 0) begin
                if (w == 0) e = m_q0.pop_front();
                else        e = m_q1.pop_front();
                m_pref = 1 - w;
                if (e.addr != 5'd0) begin
                    m_wen         = 1'b1;
                    m_waddr       = e.addr;
                    m_wdata       = e.data;
                    m_busy[e.addr] = 1'b0;
                end
            end
            if (alloc_valid && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
            if (s0_valid && m_q0.size() == 0) m_q0.push_back('{1'b1, s0_addr, s0_data});
            if (s1_valid && m_q1.size() == 0) m_q1.push_back('{1'b1, s1_addr, s1_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    initial begin
        rst_n       = 1'b0;
        alloc_valid = 1'b0;
        alloc_addr  = 5'd0;
        s0_valid    = 1'b1;
        s0_addr     = 5'd5;
        s0_data     = 32'hDEADBEEF;
        s1_valid    = 1'b0;
        s1_addr     = 5'd0;
        s1_data     = 32'd0;
        qaddr1      = 5'd5;
        qaddr2      = 5'd0;
        m_pref = 0; m_busy = 32'd0; m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        @(posedge clk);
        #1;

        // Reset held with s0_valid high
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("rst_s0_ready", 64'(s0_ready), 64'd0);
            chk("rst_wen",      64'(wen),      64'd0);
            chk("rst_waddr",    64'(waddr),    64'd0);
            chk("rst_wdata",    64'(wdata),    64'd0);
            chk("rst_qbusy1",   64'(qbusy1),   64'd0);
            advance();
        end
        rst_n = 1'b1;
        sample();
        chk("hs_ready", 64'(s0_ready), 64'd1);
        advance();
        s0_valid = 1'b0;
        sample();
        chk("lat_wen_early", 64'(wen), 64'd0);
        advance();
        sample();
        chk("lat_wen",   64'(wen),   64'd1);
        chk("lat_waddr", 64'(waddr), 64'd5);
        chk("lat_wdata", 64'(wdata), 64'hDEADBEEF);
        advance();

        // Scoreboard set by alloc, cleared by the writeback grant
        qaddr1 = 5'd7; alloc_valid = 1'b1; alloc_addr = 5'd7;
        cycle();
        alloc_valid = 1'b0; s1_valid = 1'b1; s1_addr = 5'd7; s1_data = $urandom;
        sample();
        chk("sb_busy_set", 64'(qbusy1), 64'd1);
        advance();
        s1_valid = 1'b0;
        sample();
        chk("sb_busy_grant_cycle", 64'(qbusy1), 64'd1);
        advance();
        sample();
        chk("sb_busy_cleared", 64'(qbusy1), 64'd0);
        chk("sb_wen",          64'(wen),    64'd1);
        chk("sb_waddr",        64'(waddr),  64'd7);
        advance();

        // Both sources streaming: strict alternation, no gaps
        s0_valid = 1'b1; s0_addr = 5'd1;
        s1_valid = 1'b1; s1_addr = 5'd2;
        for (int i = 0; i < 8; i++) begin
            s0_data = $urandom;
            s1_data = $urandom;
            sample();
            if (i >= 2) begin
                chk("rr_wen",   64'(wen),   64'd1);
                chk("rr_waddr", 64'(waddr), (i % 2 == 0) ? 64'd1 : 64'd2);
            end
            advance();
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        repeat (4) cycle();

        // Register 0: accepted and drained, never written, never busy
        qaddr2 = 5'd0;
        alloc_valid = 1'b1; alloc_addr = 5'd0;
        s0_valid = 1'b1; s0_addr = 5'd0; s0_data = 32'h1234;
        sample();
        chk("r0_ready", 64'(s0_ready), 64'd1);
        chk("r0_qbusy", 64'(qbusy2),   64'd0);
        advance();
        alloc_valid = 1'b0; s0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("r0_wen",   64'(wen),    64'd0);
            chk("r0_qbusy", 64'(qbusy2), 64'd0);
            advance();
        end

        // Same-edge alloc and writeback of reg 9: set wins
        qaddr1 = 5'd9;
        s1_valid = 1'b1; s1_addr = 5'd9; s1_data = $urandom;
        cycle();
        s1_valid = 1'b0; alloc_valid = 1'b1; alloc_addr = 5'd9;
        cycle();
        alloc_valid = 1'b0;
        sample();
        chk("sw_busy9", 64'(qbusy1), 64'd1);
        chk("sw_wen",   64'(wen),    64'd1);
        chk("sw_waddr", 64'(waddr),  64'd9);
        advance();

        // Reset while both slots are full
        s0_valid = 1'b1; s0_addr = 5'd3; s0_data = $urandom;
        s1_valid = 1'b1; s1_addr = 5'd4; s1_data = $urandom;
        cycle();
        s0_valid = 1'b0; s1_valid = 1'b0; rst_n = 1'b0;
        sample();
        chk("mr_s0_ready_low", 64'(s0_ready), 64'd0);
        chk("mr_s1_ready_low", 64'(s1_ready), 64'd0);
        advance();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("mr_s0_ready", 64'(s0_ready), 64'd1);
            chk("mr_s1_ready", 64'(s1_ready), 64'd1);
            chk("mr_wen",      64'(wen),      64'd0);
            advance();
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n       = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            s0_valid    = ($urandom_range(0, 99) < 60);
            s1_valid    = ($urandom_range(0, 99) < 50);
            s0_addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            s1_addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            s0_data     = $urandom;
            s1_data     = $urandom;
            alloc_valid = ($urandom_range(0, 99) < 40);
            alloc_addr  = 5'($urandom_range(0, 7));
            qaddr1      = 5'($urandom_range(0, 7));
            qaddr2      = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side front end for the integer register file.
- Merges result streams from two producers, src0 (ALU, single-cycle) and src1 (load/store unit, multi-cycle), into the register file's single write port (waddr/wdata/wen) using valid/ready handshakes and round-robin arbitration.
- Keeps a pending-write scoreboard so the read/issue side can ask whether a source register still awaits writeback.
- Register 0 is never written and never busy.

Parameters:
ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries, entry 0 hardwired zero
DATA_WIDTH, 32, register data width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
alloc_valid  input  1  issue stage marks alloc_addr as pending writeback this cycle
alloc_addr  input  ADDR_WIDTH  destination register being allocated
s0_valid  input  1  src0 result valid
s0_ready  output  1  src0 result accepted when s0_valid && s0_ready
s0_addr  input  ADDR_WIDTH  src0 destination register
s0_data  input  DATA_WIDTH  src0 result
s1_valid  input  1  src1 result valid
s1_ready  output  1  src1 accept
s1_addr  input  ADDR_WIDTH  src1 destination register
s1_data  input  DATA_WIDTH  src1 result
waddr  output  ADDR_WIDTH  register file write address, registered
wdata  output  DATA_WIDTH  register file write data, registered
wen  output  1  register file write enable, registered, one cycle per write
qaddr1  input  ADDR_WIDTH  scoreboard query address 1
qbusy1  output  1  qaddr1 has a pending write, combinational
qaddr2  input  ADDR_WIDTH  scoreboard query address 2
qbusy2  output  1  qaddr2 has a pending write, combinational

Behaviour:
- Reset (rst_n low at a rising edge):
  - wen=0, waddr=0, wdata=0.
  - Both holding slots empty, all busy bits 0, round-robin pointer = src0.
  - s0_ready=s1_ready=0 while rst_n is low.
  - Reset mid-transfer discards held entries with no write.
- Holding slots:
  - Each source has a one-entry slot (valid, addr, data).
  - sN_ready = rst_n && (slot empty || slot granted this cycle).
  - Handshake loads the slot at the edge. A granted slot and a new handshake in the same cycle reload the slot with no bubble.
- Arbitration (combinational, each cycle):
  - Candidates are full slots.
  - One candidate: grant it.
  - Both: grant the source indicated by the pointer; the pointer then moves to the other source.
  - A lone grant also sets the pointer to the non-granted source.
- Output register:
  - At the edge after a grant with addr != 0: wen=1, waddr/wdata = slot contents.
  - Otherwise wen=0; waddr/wdata hold their last values.
  - A slot with addr==0 is granted and drained normally but produces wen=0.
- Latency and throughput:
  - Handshake at edge E, grant in cycle E+1, wen high in the cycle following edge E+1, i.e. 2 cycles.
  - Sustained throughput is one write per cycle in total. With both sources streaming, each gets 1 write per 2 cycles.
- Scoreboard (2**ADDR_WIDTH busy bits; bit 0 constant 0):
  - alloc_valid with alloc_addr != 0 sets busy[alloc_addr] at the edge.
  - A grant with addr != 0 clears busy[addr] at the same edge wen is registered.
  - Set and clear of the same address at the same edge: set wins (a new producer is in flight).
  - A write to a non-busy register is legal and leaves busy at 0.
  - qbusyN = busy[qaddrN]; always 0 for qaddrN == 0. The query reflects state before the current edge, so a write being issued this cycle still reads busy.
- Both sources targeting the same register: writes are performed in grant order, with no merging.

Decomposition:
- Package rf_wb_pkg:
  - default ADDR_WIDTH/DATA_WIDTH constants
  - source index constants SRC0=0, SRC1=1
  - zero-register constant
  - slot struct typedef (valid, addr, data)
- One sub-module: rf_wb_slot, the single-entry valid/ready holding register, instantiated twice.
- Arbiter, scoreboard and output register stay in the top.

Test Plan:
- Reset held 3 cycles with s0_valid=1 → s0_ready=0, wen=0, waddr=0, wdata=0, qbusy1=0; after release, s0 write (addr 5, 0xDEADBEEF) → wen=1, waddr=5, wdata=0xDEADBEEF exactly 2 cycles after the handshake.
- alloc addr 7; query qaddr1=7 → qbusy1=1; s1 writes addr 7 → qbusy1 stays 1 in the wen cycle's preceding cycle and is 0 the cycle after the grant edge.
- Both sources valid every cycle (s0 addr 1, s1 addr 2) for 6 cycles → wen addresses 1,2,1,2,1,2 and one write per cycle with no gaps.
- s0 write to addr 0 with data 0x1234 → handshake accepted, wen stays 0, and qbusy for addr 0 is always 0, including after alloc addr 0.
- Same edge: alloc addr 9 and a grant of a write to addr 9 → after the edge, busy[9]=1 and wen=1 with waddr=9.
- rst_n low for one cycle while both slots are full → no wen afterwards, slots empty, ready=1 the cycle after release.
